// File: rtl/debug_uart_tx.sv
// debug_uart_tx: buffers debug byte strobes in a small FIFO and sends each
// byte as an 8N1 UART frame, LSB first. Back-to-back frames are contiguous.
//
// state | meaning
// IDLE  | line high, waiting for a buffered byte
// START | start bit (line low) for one bit period
// DATA  | eight data bits, LSB first, one bit period each
// STOP  | stop bit (line high); tx_Done in its last cycle, chains to START
module debug_uart_tx #(
    parameter int CLKS_PER_BIT = 217,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [7:0] tx_Data,
    input  logic       tx_DataValid,
    output logic       tx_Serial,
    output logic       tx_Active,
    output logic       tx_Done,
    output logic       fifo_full,
    output logic       overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] BAUD_LAST  = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BAUD_PRE   = BW'(CLKS_PER_BIT - 2);
    localparam logic [PW:0]   FULL_COUNT = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic [PW:0]   count_next;
    logic          push;
    logic          pop;
    logic          empty;
    logic          bit_end;

    state_t        state;
    logic [BW-1:0] baud;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    // Push/pop qualification; fullness uses the registered (pre-edge) flag
    always_comb begin
        push       = tx_DataValid & ~fifo_full;
        empty      = (count == '0);
        bit_end    = (baud == BAUD_LAST);
        pop        = ~empty & ((state == IDLE) | ((state == STOP) & bit_end));
        count_next = count;
        if (push & ~pop) begin
            count_next = count + 1'b1;
        end else if (~push & pop) begin
            count_next = count - 1'b1;
        end
    end

    // Byte storage; contents are don't-care once pointers are reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= tx_Data;
        end
    end

    // FIFO pointers, occupancy, full flag and sticky overflow
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            fifo_full <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count     <= count_next;
            fifo_full <= (count_next == FULL_COUNT);
            overflow  <= overflow | (tx_DataValid & fifo_full);
        end
    end

    // Frame sequencer with registered line, active and done outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            baud      <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            tx_Serial <= 1'b1;
            tx_Active <= 1'b0;
            tx_Done   <= 1'b0;
        end else begin
            tx_Done <= 1'b0;
            case (state)
                IDLE: begin
                    tx_Serial <= 1'b1;
                    tx_Active <= 1'b0;
                    if (pop) begin
                        shift     <= mem[rd_ptr];
                        baud      <= '0;
                        bit_idx   <= '0;
                        tx_Serial <= 1'b0;
                        tx_Active <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud      <= '0;
                        tx_Serial <= shift[0];
                        state     <= DATA;
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud    <= '0;
                        bit_idx <= bit_idx + 1'b1;
                        shift   <= {1'b0, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            tx_Serial <= 1'b1;
                            state     <= STOP;
                        end else begin
                            tx_Serial <= shift[1];
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                STOP: begin
                    // Registered pulse lands in the final stop-bit cycle
                    if (baud == BAUD_PRE) begin
                        tx_Done <= 1'b1;
                    end
                    if (bit_end) begin
                        baud <= '0;
                        if (pop) begin
                            shift     <= mem[rd_ptr];
                            bit_idx   <= '0;
                            tx_Serial <= 1'b0;
                            state     <= START;
                        end else begin
                            tx_Active <= 1'b0;
                            state     <= IDLE;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_uart_tx.sv
// Bench for debug_uart_tx: frame-level reference model (push/start edge
// bookkeeping) checked every cycle, table-driven single-frame vectors,
// hand sequences for burst, overflow, mid-frame reset and the STOP-edge gap.
module tb_debug_uart_tx;

    localparam int C  = 4;
    localparam int D  = 4;
    localparam int FL = 10 * C;

    logic       clk = 1'b0;
    logic       resetn;
    logic [7:0] tx_Data;
    logic       tx_DataValid;
    logic       tx_Serial;
    logic       tx_Active;
    logic       tx_Done;
    logic       fifo_full;
    logic       overflow;

    debug_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .tx_Data      (tx_Data),
        .tx_DataValid (tx_DataValid),
        .tx_Serial    (tx_Serial),
        .tx_Active    (tx_Active),
        .tx_Done      (tx_Done),
        .fifo_full    (fifo_full),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int e = 0;

    // Model: each accepted byte has a push edge and a frame start (pop) edge
    int         push_q[$];
    int         start_q[$];
    logic [7:0] data_q[$];
    logic       ovf_m = 1'b0;
    int         last_end = 0;

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s edge %0d: got %0h expected %0h", name, e, act, exp);
        end
    endtask

    function automatic logic frame_bit(input logic [7:0] d, input int k);
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return d[k-1];
    endfunction

    task automatic model_reset();
        push_q.delete();
        start_q.delete();
        data_q.delete();
        ovf_m    = 1'b0;
        last_end = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        e++;
    endtask

    task automatic check_outputs();
        logic es, ea, ed;
        int occ;
        es  = 1'b1;
        ea  = 1'b0;
        ed  = 1'b0;
        occ = 0;
        foreach (start_q[j]) begin
            int i;
            i = e - start_q[j];
            if (push_q[j] <= e && start_q[j] > e) occ++;
            if (i >= 0 && i < FL) begin
                ea = 1'b1;
                es = frame_bit(data_q[j], i / C);
                ed = (i == FL - 1);
            end
        end
        chk("m_serial", tx_Serial, es);
        chk("m_active", tx_Active, ea);
        chk("m_done", tx_Done, ed);
        chk("m_full", fifo_full, occ == D);
        chk("m_overflow", overflow, ovf_m);
    endtask

    // One clock: drive inputs, update model for this edge, check after edge
    task automatic step(input logic v, input logic [7:0] d);
        int occ, s;
        tx_DataValid = v;
        tx_Data      = d;
        tick();
        if (v) begin
            occ = 0;
            foreach (push_q[j]) if (push_q[j] < e && start_q[j] >= e) occ++;
            if (occ >= D) begin
                ovf_m = 1'b1;
            end else begin
                s = (e + 1 > last_end) ? e + 1 : last_end;
                push_q.push_back(e);
                start_q.push_back(s);
                data_q.push_back(d);
                last_end = s + FL;
            end
        end
        #1;
        check_outputs();
        tx_DataValid = 1'b0;
        tx_Data      = 8'h00;
    endtask

    // Asynchronous reset assertion, checked before any edge arrives
    task automatic do_reset();
        resetn = 1'b0;
        #2;
        chk("rst_serial", tx_Serial, 1'b1);
        chk("rst_active", tx_Active, 1'b0);
        chk("rst_done", tx_Done, 1'b0);
        chk("rst_full", fifo_full, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        model_reset();
        tick();
        tick();
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        int nd, na, n, didx;
        logic [7:0] rst_bytes[2];

        vecs[0] = '{8'hA5, 10'b1_1010_0101_0};
        vecs[1] = '{8'h00, 10'b1_0000_0000_0};
        vecs[2] = '{8'hFF, 10'b1_1111_1111_0};
        vecs[3] = '{8'h3C, 10'b1_0011_1100_0};
        vecs[4] = '{8'h81, 10'b1_1000_0001_0};
        rst_bytes[0] = 8'hFF;
        rst_bytes[1] = 8'h00;

        resetn       = 1'b1;
        tx_Data      = 8'h00;
        tx_DataValid = 1'b0;
        #1;
        do_reset();

        // Idle after reset
        nd = 0;
        for (int i = 0; i < 100; i++) begin
            step(1'b0, 8'h00);
            if (tx_Serial !== 1'b1 || tx_Active !== 1'b0 || overflow !== 1'b0) nd++;
        end
        chk("idle_100_cycles_bad", nd, 0);

        // Table-driven single frames
        foreach (vecs[v]) begin
            step(1'b1, vecs[v].data);
            nd   = 0;
            didx = -1;
            for (int i = 0; i < FL; i++) begin
                step(1'b0, 8'h00);
                chk("tbl_line", tx_Serial, vecs[v].frame[i / C]);
                if (tx_Done === 1'b1) begin
                    nd++;
                    didx = i + 1;
                end
            end
            chk("tbl_done_count", nd, 1);
            chk("tbl_done_cycle", didx, 40);
            step(1'b0, 8'h00);
            chk("tbl_idle_after", {tx_Serial, tx_Active}, 2'b10);
        end

        // Burst of three on consecutive cycles
        step(1'b1, 8'h01);
        na = 0;
        nd = 0;
        step(1'b1, 8'h02);
        if (tx_Active === 1'b1) na++;
        step(1'b1, 8'h03);
        if (tx_Active === 1'b1) na++;
        for (int i = 0; i < 118; i++) begin
            step(1'b0, 8'h00);
            if (tx_Active === 1'b1) na++;
            if (tx_Done === 1'b1) nd++;
        end
        chk("burst_active_cycles", na, 120);
        chk("burst_done_count", nd, 3);
        step(1'b0, 8'h00);
        chk("burst_active_end", tx_Active, 1'b0);

        // Overflow: six strobes, sixth dropped
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 8'h10 + 8'(i));
            if (i == 4) chk("ovf_full_after_fill", fifo_full, 1'b1);
        end
        chk("ovf_set", overflow, 1'b1);
        nd = 0;
        for (int i = 0; i < 5 * FL + 5; i++) begin
            step(1'b0, 8'h00);
            if (tx_Done === 1'b1) nd++;
        end
        chk("ovf_frames_sent", nd, 5);
        chk("ovf_sticky", overflow, 1'b1);
        do_reset();
        step(1'b0, 8'h00);
        chk("ovf_cleared", overflow, 1'b0);

        // Reset mid-frame during data bit 3, with bytes still buffered
        foreach (rst_bytes[r]) begin
            step(1'b1, rst_bytes[r]);
            step(1'b1, 8'h77);
            step(1'b1, 8'h66);
            for (int i = 0; i < 16; i++) step(1'b0, 8'h00);
            do_reset();
            for (int i = 0; i < 10; i++) step(1'b0, 8'h00);
            chk("rst_fifo_empty_line", {tx_Serial, tx_Active}, 2'b10);
            step(1'b1, 8'h3C);
            for (int i = 0; i < FL; i++) begin
                step(1'b0, 8'h00);
                chk("rst_clean_frame", tx_Serial, vecs[3].frame[i / C]);
            end
            step(1'b0, 8'h00);
        end

        // Strobe in the last STOP cycle with FIFO empty: one idle-high gap
        step(1'b1, 8'h5A);
        n = 0;
        while (tx_Done !== 1'b1 && n < 100) begin
            step(1'b0, 8'h00);
            n++;
        end
        chk("gap_done_seen_in_time", n < 100, 1'b1);
        step(1'b1, 8'hC3);
        chk("gap_idle_cycle", {tx_Serial, tx_Active}, 2'b10);
        step(1'b0, 8'h00);
        chk("gap_start_bit", {tx_Serial, tx_Active}, 2'b01);
        for (int i = 0; i < FL + 2; i++) step(1'b0, 8'h00);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                for (int k = 0; k < 6; k++) step(1'b1, 8'($urandom));
            end else begin
                step($urandom_range(0, 24) == 0, 8'($urandom));
            end
        end
        for (int i = 0; i < 6 * FL; i++) step(1'b0, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/debug_uart_tx.md
# debug_uart_tx

Serial transmitter for the CPU's debug byte channel. It accepts single-cycle `tx_Data`/`tx_DataValid` strobes from the datapath (ALU debug taps) and buffers them in a small FIFO. It serializes each byte onto a single line as 8N1 UART frames, LSB first. It sits between the core and the board's UART TX pin and is the transmitting end of the core's `tx_Data`/`tx_DataValid` debug interface.

## Interface
- `CLKS_PER_BIT`, default 217: clock cycles per serial bit (25 MHz / 115200 baud); must be ≥ 2.
- `FIFO_DEPTH`, default 4: byte buffer entries; must be a power of two, ≥ 2.
- `clk`  input  1  single system clock; all logic on its rising edge.
- `resetn`  input  1  asynchronous, active-low reset.
- `tx_Data`  input  8  byte to send; sampled when `tx_DataValid`=1.
- `tx_DataValid`  input  1  write strobe; each high cycle is one byte request.
- `tx_Serial`  output  1  UART line; idles high.
- `tx_Active`  output  1  high while a frame (start..stop) is on the line.
- `tx_Done`  output  1  one-cycle pulse in the last cycle of each stop bit.
- `fifo_full`  output  1  FIFO holds `FIFO_DEPTH` bytes.
- `overflow`  output  1  sticky: a strobe was dropped because the FIFO was full.

## Operation
- FIFO:
  - On an edge with `tx_DataValid`=1 and `fifo_full`=0, `tx_Data` is pushed.
  - If `fifo_full`=1, the byte is dropped and `overflow` is set. This holds even if a pop occurs in the same cycle, because fullness is evaluated from the pre-edge count.
  - `overflow` clears only on reset.
  - Pointers are log2(`FIFO_DEPTH`) bits wide and wrap naturally. The count is one bit wider.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: `tx_Serial`=1. If the FIFO is non-empty, pop the head into the shift register, clear the baud counter and bit index, then go to START.
  - START: `tx_Serial`=0 for `CLKS_PER_BIT` cycles, then go to DATA.
  - DATA: `tx_Serial`=shift[0] for `CLKS_PER_BIT` cycles per bit. At each bit end, shift right and increment the 3-bit index. After index 7 completes, go to STOP.
  - STOP: `tx_Serial`=1 for `CLKS_PER_BIT` cycles. In the last cycle, `tx_Done`=1. If the FIFO is non-empty at that edge, pop and go directly to START, with no idle gap. Otherwise go to IDLE.
- Baud counter: counts 0..`CLKS_PER_BIT`-1 and resets to 0 on each bit end. Width is clog2(`CLKS_PER_BIT`).
- `tx_Active`=1 in START, DATA and STOP.
- All outputs are registered. `tx_Serial` never glitches.
- Reset values: `tx_Serial`=1, `tx_Active`=0, `tx_Done`=0, `fifo_full`=0, `overflow`=0, FIFO empty, FSM in IDLE, counters 0.
- Reset asserted mid-frame aborts the frame immediately. The line returns high asynchronously and buffered bytes are discarded.

## Timing
- Push at edge N into an empty FIFO with the FSM in IDLE: FSM enters START at edge N+1, and `tx_Serial` goes low after edge N+1.
- Frame length is exactly 10×`CLKS_PER_BIT` cycles: start bit, then bits 0..7, then stop bit.
- Back-to-back frames are contiguous: the next start bit begins on the cycle after the previous stop bit's last cycle.
- The FIFO frees a slot on the pop edge, so `fifo_full` falls the cycle after the pop.
- Throughput: one byte per 10×`CLKS_PER_BIT` cycles. Sustained strobes faster than this fill the FIFO and then set `overflow`.

## Test plan
- Reset then idle (`CLKS_PER_BIT`=4): `tx_Serial`=1, `tx_Active`=0 and `overflow`=0 hold for 100 cycles.
- Single byte 0xA5 (`CLKS_PER_BIT`=4):
  - Line sequence is 0, then 1,0,1,0,0,1,0,1, then 1, each level held 4 cycles.
  - Start bit begins one cycle after the strobe.
  - `tx_Done` pulses once, at cycle 40 of the frame.
- Burst of 0x01, 0x02, 0x03 on consecutive cycles: three frames with no gap; `tx_Active` stays high for 120 cycles; `tx_Done` pulses 3 times.
- Overflow (`FIFO_DEPTH`=4): six consecutive strobes 0x10..0x15.
  - 0x10 is popped immediately, so 0x11..0x14 fill the FIFO.
  - 0x15 is dropped and `overflow`=1.
  - Exactly 0x10..0x14 appear on the line.
  - `overflow` stays 1 until reset.
- Reset mid-frame: assert `resetn`=0 during bit 3 of 0xFF.
  - `tx_Serial` goes to 1 without waiting for a clock edge; FIFO is empty.
  - After release, a new strobe of 0x3C transmits a clean frame.
- Strobe during STOP last cycle with FIFO empty: byte is pushed. FSM goes STOP→IDLE→START, giving a one-cycle idle-high gap before the start bit.
